// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_pkg;

    localparam int unsigned        INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_SQUASH
    } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register holding a fetched {instr, pcplus4} while IF/ID is stalled.
module if_skid_buf
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [31:0]        pcplus4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pcplus4,
    output logic               full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr   <= '0;
            pcplus4 <= '0;
            full    <= 1'b0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            full    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, imem req/gnt/rvalid handshake, IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_cnt / squash_cnt performance counters.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0]        RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_d,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pc_f,
    output logic [INSTR_W-1:0] instr_d,
    output logic [31:0]        pcplus4_d,
    output logic               valid_d
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        squash_cnt
`endif
);

    if_state_t          state, state_n;
    logic [31:0]        fa, fa_n, pc_n, pcplus4_n;
    logic [INSTR_W-1:0] instr_n;
    logic               valid_n, free;
    logic               skid_load, skid_unload, skid_clear, skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [31:0]        skid_pcplus4;

    if_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .instr_in   (imem_rdata),
        .pcplus4_in (fa + 32'd4),
        .instr      (skid_instr),
        .pcplus4    (skid_pcplus4),
        .full       (skid_full)
    );

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc_f;
    assign free      = !valid_d || !stall_d;

    always_comb begin
        state_n     = state;
        pc_n        = pc_f;
        fa_n        = fa;
        instr_n     = instr_d;
        pcplus4_n   = pcplus4_d;
        valid_n     = valid_d && stall_d;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        unique case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    fa_n    = pc_f;
                    pc_n    = pc_f + 32'd4;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (free) begin
                        instr_n   = imem_rdata;
                        pcplus4_n = fa + 32'd4;
                        valid_n   = 1'b1;
                        state_n   = S_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_n   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_d && skid_full) begin
                    instr_n     = skid_instr;
                    pcplus4_n   = skid_pcplus4;
                    valid_n     = 1'b1;
                    skid_unload = 1'b1;
                    state_n     = S_REQ;
                end
            end
            S_SQUASH: begin
                if (imem_rvalid) state_n = S_REQ;
            end
            default: state_n = S_IDLE;
        endcase

        if (redirect_en) begin
            pc_n        = redirect_pc & ~32'd3;
            valid_n     = 1'b0;
            instr_n     = NOP_INSTR;
            pcplus4_n   = pcplus4_d;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            skid_clear  = 1'b1;
            unique case (state)
                S_REQ:    state_n = imem_gnt    ? S_SQUASH : S_REQ;
                S_WAIT:   state_n = imem_rvalid ? S_REQ    : S_SQUASH;
                // a response landing in the same cycle completes the squash
                S_SQUASH: state_n = imem_rvalid ? S_REQ    : S_SQUASH;
                default:  state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc_f      <= RESET_PC;
            fa        <= '0;
            instr_d   <= NOP_INSTR;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else begin
            state     <= state_n;
            pc_f      <= pc_n;
            fa        <= fa_n;
            instr_d   <= instr_n;
            pcplus4_d <= pcplus4_n;
            valid_d   <= valid_n;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_inc, squash_inc;

    assign fetch_inc  = imem_rvalid && (state == S_WAIT) && !redirect_en;
    assign squash_inc = imem_rvalid && ((state == S_SQUASH) ||
                                        ((state == S_WAIT) && redirect_en));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (fetch_inc)  fetch_cnt  <= fetch_cnt + 32'd1;
            if (squash_inc) squash_cnt <= squash_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a simple single-outstanding imem model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic        gnt_en, resp_block, pend, issue_now;
    logic [31:0] pend_addr, issue_addr;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_d     (stall_d),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the memory model: grant when enabled, answer the cycle after grant.
    task automatic cycle();
        @(negedge clk);
        imem_gnt    = gnt_en && imem_req;
        imem_rvalid = pend && !resp_block;
        imem_rdata  = imem_rvalid ? word(pend_addr) : 32'hDEAD_BEEF;
        issue_now   = imem_gnt;
        issue_addr  = imem_addr;
        @(posedge clk);
        #1;
        if (imem_rvalid) pend = 1'b0;
        if (issue_now) begin
            pend      = 1'b1;
            pend_addr = issue_addr;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall_d = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        gnt_en = 1'b1; resp_block = 1'b0; pend = 1'b0; pend_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        issue_now = 1'b0; issue_addr = '0;

        #1;
        check("rst_pc_f",    pc_f,      32'h0);
        check("rst_instr",   instr_d,   32'h0);
        check("rst_pcplus4", pcplus4_d, 32'h0);
        check("rst_valid",   valid_d,   32'h0);
        check("rst_req",     imem_req,  32'h0);
        cycle(); cycle();
        reset = 1'b1;

        cycle();
        check("idle_req",  imem_req,  32'h1);
        check("idle_addr", imem_addr, 32'h0);
        cycle();
        check("g0_valid", valid_d, 32'h0);
        check("g0_pc_f",  pc_f,    32'h4);
        cycle();
        check("r0_valid",   valid_d,   32'h1);
        check("r0_instr",   instr_d,   word(32'h0));
        check("r0_pcplus4", pcplus4_d, 32'h4);
        check("r0_addr",    imem_addr, 32'h4);
        cycle(); cycle();
        check("r4_instr",   instr_d,   word(32'h4));
        check("r4_pcplus4", pcplus4_d, 32'h8);
        check("r4_addr",    imem_addr, 32'h8);

        stall_d = 1'b1;
        cycle();
        check("stall_valid_held", valid_d, 32'h1);
        check("stall_pc_f",       pc_f,    32'hC);
        cycle();
        check("skid_req",   imem_req, 32'h0);
        check("skid_instr", instr_d,  word(32'h4));
        cycle(); cycle();
        check("hold_instr",   instr_d,   word(32'h4));
        check("hold_pcplus4", pcplus4_d, 32'h8);
        check("hold_req",     imem_req,  32'h0);
        stall_d = 1'b0;
        cycle();
        check("unskid_instr",   instr_d,   word(32'h8));
        check("unskid_pcplus4", pcplus4_d, 32'hC);
        check("unskid_valid",   valid_d,   32'h1);
        check("unskid_req",     imem_req,  32'h1);
        check("unskid_addr",    imem_addr, 32'hC);
        cycle(); cycle();
        check("rC_pcplus4", pcplus4_d, 32'h10);
        check("rC_addr",    imem_addr, 32'h10);

        cycle();
        redirect_en = 1'b1; redirect_pc = 32'h0000_0103; resp_block = 1'b1;
        cycle();
        redirect_en = 1'b0; resp_block = 1'b0;
        check("rdw_valid", valid_d,  32'h0);
        check("rdw_instr", instr_d,  32'h0);
        check("rdw_req",   imem_req, 32'h0);
        check("rdw_pc_f",  pc_f,     32'h100);
        cycle();
        check("sq_instr", instr_d,   32'h0);
        check("sq_valid", valid_d,   32'h0);
        check("sq_req",   imem_req,  32'h1);
        check("sq_addr",  imem_addr, 32'h100);
        cycle(); cycle();
        check("r100_instr",   instr_d,   word(32'h100));
        check("r100_pcplus4", pcplus4_d, 32'h104);

        redirect_en = 1'b1; redirect_pc = 32'h20; gnt_en = 1'b0;
        cycle();
        redirect_en = 1'b0; gnt_en = 1'b1;
        check("rdq_req",   imem_req,  32'h1);
        check("rdq_addr",  imem_addr, 32'h20);
        check("rdq_valid", valid_d,   32'h0);
        cycle();
        redirect_en = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_en = 1'b0;
        check("rdv_valid", valid_d,   32'h0);
        check("rdv_instr", instr_d,   32'h0);
        check("rdv_req",   imem_req,  32'h1);
        check("rdv_addr",  imem_addr, 32'h40);
        cycle(); cycle();
        check("r40_instr",   instr_d,   word(32'h40));
        check("r40_pcplus4", pcplus4_d, 32'h44);
        check("r40_valid",   valid_d,   32'h1);

        redirect_en = 1'b1; redirect_pc = 32'h80;
        cycle();
        redirect_en = 1'b0;
        check("rdg_req",  imem_req, 32'h0);
        check("rdg_pc_f", pc_f,     32'h80);
        cycle();
        check("rdg_instr", instr_d,   32'h0);
        check("rdg_addr",  imem_addr, 32'h80);
        check("rdg_req2",  imem_req,  32'h1);
        cycle(); cycle();
        check("r80_instr",   instr_d,   word(32'h80));
        check("r80_pcplus4", pcplus4_d, 32'h84);
`ifdef IF_PERF_CNT_EN
        check("pre_fetch_cnt",  fetch_cnt,  32'd7);
        check("pre_squash_cnt", squash_cnt, 32'd3);
`endif

        cycle();
        check("g84_pc_f", pc_f, 32'h88);
        reset = 1'b0;
        #1;
        check("mid_rst_pc_f",    pc_f,      32'h0);
        check("mid_rst_instr",   instr_d,   32'h0);
        check("mid_rst_pcplus4", pcplus4_d, 32'h0);
        check("mid_rst_valid",   valid_d,   32'h0);
        check("mid_rst_req",     imem_req,  32'h0);
        cycle();
        check("late_rv_instr", instr_d, 32'h0);
        check("late_rv_valid", valid_d, 32'h0);
        cycle();
        reset = 1'b1;
        cycle();
        check("post_rst_req",  imem_req,  32'h1);
        check("post_rst_addr", imem_addr, 32'h0);
        cycle(); cycle();
        check("post_rst_instr",   instr_d,   word(32'h0));
        check("post_rst_pcplus4", pcplus4_d, 32'h4);

        for (int i = 1; i <= 9; i++) begin
            cycle(); cycle();
            check("seq_pcplus4", pcplus4_d, 32'(4 * (i + 1)));
        end
        check("seq_addr", imem_addr, 32'h28);

        cycle();
        redirect_en = 1'b1; redirect_pc = 32'h200; resp_block = 1'b1;
        cycle();
        redirect_en = 1'b0; resp_block = 1'b0;
        check("sq1_req", imem_req, 32'h0);
        cycle();
        check("sq1_addr",  imem_addr, 32'h200);
        check("sq1_valid", valid_d,   32'h0);
        cycle();
        redirect_en = 1'b1; redirect_pc = 32'h300; resp_block = 1'b1;
        cycle();
        redirect_en = 1'b0; resp_block = 1'b0;
        cycle();
        check("sq2_addr", imem_addr, 32'h300);
        check("sq2_req",  imem_req,  32'h1);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt",  fetch_cnt,  32'd10);
        check("squash_cnt", squash_cnt, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
